// File: rtl/bcd2binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// One shift/correct step per clock; start/busy/done handshake.

module bcd2binary_digit (
   input  logic [3:0] raw,
   input  logic [3:0] shifted,
   output logic [3:0] corrected,
   output logic       invalid
);

   assign invalid   = (raw > 4'd9);
   assign corrected = (shifted >= 4'd8) ? (shifted - 4'd3) : shifted;

endmodule

module bcd2binary_seq #(
   parameter int NDIGITS = 3,
   parameter int BIN_W   = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*NDIGITS-1:0]   bcd,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [BIN_W-1:0]       bin
);

   localparam int BCD_W = 4 * NDIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_DONE
   } state_t;

   state_t             state, state_next;
   logic [BCD_W-1:0]   bcd_reg, bcd_reg_next;
   logic [BIN_W-1:0]   work_bin, work_bin_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic               busy_next, done_next, err_next;
   logic [BIN_W-1:0]   bin_next;

   logic [NDIGITS-1:0] bad;
   logic [BCD_W-1:0]   shifted_bcd, corr_bcd;
   logic [BIN_W-1:0]   shifted_bin;

   // The LSB of the BCD part falls into the MSB of the binary part.
   assign shifted_bcd = {1'b0, bcd_reg[BCD_W-1:1]};
   assign shifted_bin = {bcd_reg[0], work_bin[BIN_W-1:1]};

   genvar gi;
   generate
      for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
         bcd2binary_digit u_digit (
            .raw       (bcd[4*gi +: 4]),
            .shifted   (shifted_bcd[4*gi +: 4]),
            .corrected (corr_bcd[4*gi +: 4]),
            .invalid   (bad[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         bcd_reg  <= '0;
         work_bin <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         bin      <= '0;
      end else begin
         state    <= state_next;
         bcd_reg  <= bcd_reg_next;
         work_bin <= work_bin_next;
         cnt      <= cnt_next;
         busy     <= busy_next;
         done     <= done_next;
         err      <= err_next;
         bin      <= bin_next;
      end
   end

   always_comb begin
      state_next    = state;
      bcd_reg_next  = bcd_reg;
      work_bin_next = work_bin;
      cnt_next      = cnt;
      busy_next     = 1'b0;
      done_next     = 1'b0;
      err_next      = err;
      bin_next      = bin;

      case (state)
         S_IDLE: begin
            if (start) begin
               bcd_reg_next = bcd;
               if (|bad) begin
                  // Bad digit: report immediately, skip the conversion.
                  err_next   = 1'b1;
                  bin_next   = '0;
                  done_next  = 1'b1;
                  state_next = S_DONE;
               end else begin
                  err_next      = 1'b0;
                  cnt_next      = '0;
                  work_bin_next = '0;
                  busy_next     = 1'b1;
                  state_next    = S_CONV;
               end
            end
         end

         S_CONV: begin
            bcd_reg_next  = corr_bcd;
            work_bin_next = shifted_bin;
            cnt_next      = cnt + CNT_W'(1);
            busy_next     = 1'b1;
            if (cnt == CNT_W'(BIN_W - 1)) begin
               bin_next   = shifted_bin;
               busy_next  = 1'b0;
               done_next  = 1'b1;
               state_next = S_DONE;
            end
         end

         S_DONE: begin
            state_next = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bcd2binary_seq.sv
// Randomized and directed bench for bcd2binary_seq against a schedule/arithmetic model.

module tb_bcd2binary_seq;

   localparam int NDIGITS = 3;
   localparam int BIN_W   = 10;

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic [4*NDIGITS-1:0] bcd;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [BIN_W-1:0]     bin;

   int checks   = 0;
   int failures = 0;

   bcd2binary_seq #(.NDIGITS(NDIGITS), .BIN_W(BIN_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bcd   (bcd),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .bin   (bin)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Decimal value of a packed BCD word; -1 if any digit is not decimal.
   function automatic int bcd_value(input logic [4*NDIGITS-1:0] w);
      int v = 0;
      int scale = 1;
      for (int i = 0; i < NDIGITS; i++) begin
         if (w[4*i +: 4] > 4'd9) return -1;
         v = v + int'(w[4*i +: 4]) * scale;
         scale = scale * 10;
      end
      return v;
   endfunction

   function automatic logic [4*NDIGITS-1:0] rand_bcd();
      logic [4*NDIGITS-1:0] w;
      for (int i = 0; i < NDIGITS; i++) begin
         if ($urandom_range(0, 7) == 0) w[4*i +: 4] = 4'($urandom_range(0, 15));
         else                           w[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      return w;
   endfunction

   // Model: a transaction schedule in edge numbers plus decimal arithmetic.
   int               e         = 0;
   int               idle_from = 0;
   int               done_edge = -1;
   int               busy_end  = -1;
   logic [BIN_W-1:0] pend_bin  = '0;
   logic [BIN_W-1:0] m_bin     = '0;
   logic             m_err     = 1'b0;
   logic             m_busy    = 1'b0;
   logic             m_done    = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_from = e + 1;
         done_edge = -1;
         busy_end  = -1;
         m_bin     = '0;
         m_err     = 1'b0;
         m_busy    = 1'b0;
         m_done    = 1'b0;
      end else begin
         int v;
         e++;
         m_done = (e == done_edge);
         if (m_done) m_bin = pend_bin;
         m_busy = (e < busy_end);
         if (start && e >= idle_from) begin
            v = bcd_value(bcd);
            if (v < 0) begin
               m_err     = 1'b1;
               m_bin     = '0;
               m_done    = 1'b1;
               done_edge = e;
               idle_from = e + 2;
            end else begin
               m_err     = 1'b0;
               m_busy    = 1'b1;
               busy_end  = e + BIN_W;
               done_edge = e + BIN_W;
               pend_bin  = BIN_W'(v);
               idle_from = e + BIN_W + 2;
            end
         end
      end
   end

   bit cmp_en = 1'b0;

   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         check("busy", 32'(busy), 32'(m_busy));
         check("done", 32'(done), 32'(m_done));
         check("err",  32'(err),  32'(m_err));
         check("bin",  32'(bin),  32'(m_bin));
      end
   end

   task automatic conv(input logic [4*NDIGITS-1:0] v, input int exp_val,
                       input logic exp_e, input int exp_lat);
      int k;
      @(negedge clk);
      start = 1'b1;
      bcd   = v;
      @(negedge clk);
      start = 1'b0;
      bcd   = rand_bcd();
      k = 1;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("latency", 32'(k), 32'(exp_lat));
      check("lit_bin", 32'(bin), 32'(exp_val));
      check("lit_err", 32'(err), 32'(exp_e));
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      int k;
      rst   = 1'b1;
      start = 1'b0;
      bcd   = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err",  32'(err),  32'd0);
      check("rst_bin",  32'(bin),  32'd0);
      rst = 1'b0;
      cmp_en = 1'b1;

      conv(12'h000,   0, 1'b0, BIN_W + 1);
      conv(12'h255, 255, 1'b0, BIN_W + 1);
      conv(12'h123, 123, 1'b0, BIN_W + 1);
      conv(12'h047,  47, 1'b0, BIN_W + 1);
      conv(12'h999, 999, 1'b0, BIN_W + 1);
      conv(12'h1A3,   0, 1'b1, 1);

      // Starts during a conversion must be ignored.
      @(negedge clk);
      start = 1'b1;
      bcd   = 12'h099;
      @(negedge clk);
      start = 1'b0;
      bcd   = rand_bcd();
      k = 1;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
         if (k == 3 || k == 8) begin
            start = 1'b1;
            bcd   = 12'h555;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check("ign_latency", 32'(k), 32'(BIN_W + 1));
      check("ign_bin", 32'(bin), 32'd99);
      @(negedge clk);
      conv(12'h555, 555, 1'b0, BIN_W + 1);

      // Reset in the middle of a conversion.
      @(negedge clk);
      start = 1'b1;
      bcd   = 12'h750;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_err",  32'(err),  32'd0);
      check("midrst_bin",  32'(bin),  32'd0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      repeat (BIN_W + 3) begin
         @(negedge clk);
         check("no_done_after_rst", 32'(done), 32'd0);
      end
      conv(12'h010, 10, 1'b0, BIN_W + 1);

      // Random start/bcd traffic, checked every cycle by the model.
      repeat (600) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) != 0);
         bcd   = rand_bcd();
      end
      // Start held high: back-to-back acceptance in every IDLE cycle.
      start = 1'b1;
      repeat (80) begin
         @(negedge clk);
         bcd = rand_bcd();
      end
      start = 1'b0;
      repeat (BIN_W + 4) @(negedge clk);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
